// File: rtl/apb_controller.sv
// AHB-to-APB bridge control FSM.
// Takes one AHB transfer at a time and turns it into an APB SETUP/ENABLE pair.
// While the transfer is in progress, hreadyout is held low to stall the AHB master.
//
// Handshake: an AHB address phase is accepted on a rising edge only when
// hreadyout=1, valid=1 and hselx is non-zero. While hreadyout=0, the AHB
// inputs are ignored. The APB side needs no handshake because the slaves
// are zero-wait: each access is exactly one SETUP cycle followed by one
// ENABLE cycle.
module apb_controller #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_SLAVES = 3
) (
   input  logic                  hclk,
   input  logic                  hreset,
   input  logic                  valid,
   input  logic [ADDR_WIDTH-1:0] haddr,
   input  logic                  hwrite,
   input  logic [NUM_SLAVES-1:0] hselx,
   input  logic [DATA_WIDTH-1:0] hwdata,
   input  logic [DATA_WIDTH-1:0] prdata,
   output logic                  pwrite,
   output logic                  penable,
   output logic [NUM_SLAVES-1:0] psel,
   output logic [ADDR_WIDTH-1:0] paddr,
   output logic [DATA_WIDTH-1:0] pwdata,
   output logic                  hreadyout,
   output logic [DATA_WIDTH-1:0] hrdata,
   output logic [1:0]            fsm_state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WWAIT  = 2'd1,
      SETUP  = 2'd2,
      ENABLE = 2'd3
   } state_t;

   state_t                state;
   logic [NUM_SLAVES-1:0] sel_q;
   logic                  accept;

   // A new address phase is taken only when the bridge is ready and a mapped slave is selected.
   assign accept = hreadyout && valid && (|hselx);

   // Bridge FSM. hreadyout, psel and penable are registered together with the next state,
   // so each one is a clean function of the current state.
   always_ff @(posedge hclk) begin
      if (hreset) begin
         state     <= IDLE;
         hreadyout <= 1'b1;
         psel      <= '0;
         penable   <= 1'b0;
         paddr     <= '0;
         pwdata    <= '0;
         pwrite    <= 1'b0;
         sel_q     <= '0;
      end else begin
         case (state)
            IDLE, ENABLE: begin
               if (accept) begin
                  paddr   <= haddr;
                  pwrite  <= hwrite;
                  sel_q   <= hselx;
                  penable <= 1'b0;
                  hreadyout <= 1'b0;
                  if (hwrite) begin
                     // Write data arrives one cycle later, so select nothing while waiting for it.
                     state <= WWAIT;
                     psel  <= '0;
                  end else begin
                     state <= SETUP;
                     psel  <= hselx;
                  end
               end else begin
                  state     <= IDLE;
                  hreadyout <= 1'b1;
                  psel      <= '0;
                  penable   <= 1'b0;
               end
            end
            WWAIT: begin
               pwdata    <= hwdata;
               state     <= SETUP;
               psel      <= sel_q;
               penable   <= 1'b0;
               hreadyout <= 1'b0;
            end
            SETUP: begin
               state     <= ENABLE;
               penable   <= 1'b1;
               hreadyout <= 1'b1;
            end
            default: begin
               state     <= IDLE;
               hreadyout <= 1'b1;
               psel      <= '0;
               penable   <= 1'b0;
            end
         endcase
      end
   end

   // Read data is passed through only during the ENABLE cycle of a read.
   always_comb begin
      hrdata = '0;
      if (state == ENABLE && !pwrite)
         hrdata = prdata;
   end

   assign fsm_state = state;

endmodule

// File: tb/tb_apb_controller.sv
// Bench for apb_controller. It runs directed transfers and checks the cycle-level
// outputs inline. A monitor compares every APB ENABLE cycle against a queue of
// expected accesses.
module tb_apb_controller;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 3;
  localparam int EW = NS + AW + 1 + DW + DW;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WWAIT  = 2'd1;
  localparam logic [1:0] S_SETUP  = 2'd2;
  localparam logic [1:0] S_ENABLE = 2'd3;

  logic          hclk = 1'b0;
  logic          hreset;
  logic          valid;
  logic [AW-1:0] haddr;
  logic          hwrite;
  logic [NS-1:0] hselx;
  logic [DW-1:0] hwdata;
  logic [DW-1:0] prdata;
  logic          pwrite;
  logic          penable;
  logic [NS-1:0] psel;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          hreadyout;
  logic [DW-1:0] hrdata;
  logic [1:0]    fsm_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] last_wdata = '0;

  apb_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS)) dut (
    .hclk(hclk), .hreset(hreset), .valid(valid), .haddr(haddr), .hwrite(hwrite),
    .hselx(hselx), .hwdata(hwdata), .prdata(prdata), .pwrite(pwrite),
    .penable(penable), .psel(psel), .paddr(paddr), .pwdata(pwdata),
    .hreadyout(hreadyout), .hrdata(hrdata), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 hclk = ~hclk;

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  // driver tasks: each starts one cycle after an edge with hreadyout=1 and
  // returns one cycle after the edge that enters ENABLE
  task automatic do_write(input logic [AW-1:0] a, input logic [NS-1:0] s, input logic [DW-1:0] d);
    valid = 1'b1; hwrite = 1'b1; haddr = a; hselx = s;
    exp_q.push_back({s, a, 1'b1, d, {DW{1'b0}}});
    step();
    chk("wwait_state", EW'(fsm_state), EW'(S_WWAIT));
    chk("wwait_hready", EW'(hreadyout), EW'(0));
    chk("wwait_psel", EW'(psel), EW'(0));
    valid = 1'b0; hwdata = d;
    step();
    chk("wsetup_psel", EW'(psel), EW'(s));
    chk("wsetup_penable", EW'(penable), EW'(0));
    chk("wsetup_paddr", EW'(paddr), EW'(a));
    chk("wsetup_pwdata", EW'(pwdata), EW'(d));
    chk("wsetup_pwrite", EW'(pwrite), EW'(1));
    chk("wsetup_hready", EW'(hreadyout), EW'(0));
    hwdata = '0;
    step();
    chk("wenable_penable", EW'(penable), EW'(1));
    chk("wenable_hready", EW'(hreadyout), EW'(1));
    chk("wenable_psel", EW'(psel), EW'(s));
    last_wdata = d;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [NS-1:0] s, input logic [DW-1:0] r);
    valid = 1'b1; hwrite = 1'b0; haddr = a; hselx = s;
    exp_q.push_back({s, a, 1'b0, last_wdata, r});
    step();
    chk("rsetup_state", EW'(fsm_state), EW'(S_SETUP));
    chk("rsetup_psel", EW'(psel), EW'(s));
    chk("rsetup_penable", EW'(penable), EW'(0));
    chk("rsetup_hready", EW'(hreadyout), EW'(0));
    chk("rsetup_hrdata", EW'(hrdata), EW'(0));
    valid = 1'b0; prdata = r;
    step();
    chk("renable_penable", EW'(penable), EW'(1));
    chk("renable_hready", EW'(hreadyout), EW'(1));
    chk("renable_hrdata", EW'(hrdata), EW'(r));
  endtask

  task automatic go_idle();
    valid = 1'b0;
    step();
    chk("idle_state", EW'(fsm_state), EW'(S_IDLE));
    chk("idle_hready", EW'(hreadyout), EW'(1));
    chk("idle_psel", EW'(psel), EW'(0));
    chk("idle_penable", EW'(penable), EW'(0));
  endtask

  // scoreboard monitor: every APB ENABLE cycle must match the next expected access
  always @(negedge hclk) begin
    if (!hreset) begin
      if (psel != '0 && penable) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_access", {psel, paddr, pwrite, pwdata, hrdata}, '0);
        end else begin
          chk("apb_access", {psel, paddr, pwrite, pwdata, hrdata}, exp_q.pop_front());
        end
      end else begin
        chk("hrdata_zero", EW'(hrdata), EW'(0));
      end
    end
  end

  initial begin
    hreset = 1'b1; valid = 1'b0; haddr = '0; hwrite = 1'b0; hselx = '0;
    hwdata = '0; prdata = '0;
    step();
    step();
    chk("rst_hready", EW'(hreadyout), EW'(1));
    chk("rst_psel", EW'(psel), EW'(0));
    chk("rst_penable", EW'(penable), EW'(0));
    chk("rst_paddr", EW'(paddr), EW'(0));
    chk("rst_pwdata", EW'(pwdata), EW'(0));
    chk("rst_pwrite", EW'(pwrite), EW'(0));
    chk("rst_state", EW'(fsm_state), EW'(S_IDLE));
    hreset = 1'b0;
    step();

    // single write, then single read
    do_write(32'h8000_0010, 3'b001, 32'hDEAD_BEEF);
    go_idle();
    do_read(32'h8400_0020, 3'b010, 32'h0000_005A);
    go_idle();

    // back-to-back: read->write, write->write, write->read, read->read
    do_read(32'h8400_0044, 3'b100, 32'h1234_5678);
    do_write(32'h8000_0080, 3'b100, 32'hCAFE_F00D);
    do_write(32'h8000_0084, 3'b001, 32'h0BAD_F00D);
    do_read(32'h8400_0048, 3'b010, 32'hA5A5_0001);
    do_read(32'h8400_004C, 3'b001, 32'h0000_FFFF);
    go_idle();

    // reset during the SETUP of a write: the access is dropped
    valid = 1'b1; hwrite = 1'b1; haddr = 32'h8000_0100; hselx = 3'b010;
    step();
    valid = 1'b0; hwdata = 32'h1111_2222;
    step();
    chk("pre_rst_setup", EW'(fsm_state), EW'(S_SETUP));
    hreset = 1'b1;
    step();
    hreset = 1'b0;
    chk("mid_rst_psel", EW'(psel), EW'(0));
    chk("mid_rst_penable", EW'(penable), EW'(0));
    chk("mid_rst_hready", EW'(hreadyout), EW'(1));
    chk("mid_rst_state", EW'(fsm_state), EW'(S_IDLE));
    chk("mid_rst_paddr", EW'(paddr), EW'(0));
    last_wdata = '0;
    go_idle();

    // valid with no slave selected is ignored
    valid = 1'b1; hwrite = 1'b0; haddr = 32'h1234_5678; hselx = 3'b000;
    step();
    chk("nosel_state", EW'(fsm_state), EW'(S_IDLE));
    chk("nosel_paddr", EW'(paddr), EW'(0));
    chk("nosel_hready", EW'(hreadyout), EW'(1));

    // valid pulsed while hreadyout=0 (read SETUP) is ignored
    haddr = 32'h8400_0200; hselx = 3'b100;
    exp_q.push_back({3'b100, 32'h8400_0200, 1'b0, last_wdata, 32'h0000_0077});
    step();
    haddr = 32'hFFFF_FFF0; hselx = 3'b001; hwrite = 1'b1; prdata = 32'h0000_0077;
    step();
    valid = 1'b0;
    chk("stall_paddr", EW'(paddr), EW'(32'h8400_0200));
    chk("stall_pwrite", EW'(pwrite), EW'(0));
    chk("stall_enable", EW'(fsm_state), EW'(S_ENABLE));
    go_idle();

    // valid pulsed during WWAIT is ignored
    do_write(32'h8000_0300, 3'b010, 32'h7777_8888);
    go_idle();
    valid = 1'b1; hwrite = 1'b1; haddr = 32'h8000_0304; hselx = 3'b001;
    exp_q.push_back({3'b001, 32'h8000_0304, 1'b1, 32'h9999_AAAA, {DW{1'b0}}});
    step();
    hwrite = 1'b0; haddr = 32'hEEEE_0000; hselx = 3'b100; hwdata = 32'h9999_AAAA;
    step();
    valid = 1'b0;
    chk("wwait_stall_paddr", EW'(paddr), EW'(32'h8000_0304));
    chk("wwait_stall_psel", EW'(psel), EW'(3'b001));
    step();
    go_idle();
    go_idle();

    chk("queue_drained", EW'(exp_q.size()), EW'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
